// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: bundle between the SEQ phase sequencer and the datapath units.
// The master side is the sequencer itself; the slave side is the fetch,
// execute and memory units plus whoever issues start.
// When SEQ_CTRL_RETIRE_CNT_EN is defined the bundle also carries the
// 32-bit retired-instruction count.
interface seq_ctrl_if;
  logic        start;
  logic [3:0]  in_code;
  logic [63:0] val_p;
  logic [63:0] val_c;
  logic        flag_halt;
  logic        bad_mem;
  logic        in_error;
  logic        cnd;
  logic [63:0] val_m;
  logic        mem_ready;
  logic [63:0] p_ctr;
  logic        fetch_en;
  logic        decode_en;
  logic        exec_en;
  logic        mem_en;
  logic        wb_en;
  logic [2:0]  stat;
  logic        busy;
`ifdef SEQ_CTRL_RETIRE_CNT_EN
  logic [31:0] retired;

  modport master (
    input  start, in_code, val_p, val_c, flag_halt, bad_mem, in_error,
           cnd, val_m, mem_ready,
    output p_ctr, fetch_en, decode_en, exec_en, mem_en, wb_en, stat, busy,
           retired
  );

  modport slave (
    output start, in_code, val_p, val_c, flag_halt, bad_mem, in_error,
           cnd, val_m, mem_ready,
    input  p_ctr, fetch_en, decode_en, exec_en, mem_en, wb_en, stat, busy,
           retired
  );
`else
  modport master (
    input  start, in_code, val_p, val_c, flag_halt, bad_mem, in_error,
           cnd, val_m, mem_ready,
    output p_ctr, fetch_en, decode_en, exec_en, mem_en, wb_en, stat, busy
  );

  modport slave (
    output start, in_code, val_p, val_c, flag_halt, bad_mem, in_error,
           cnd, val_m, mem_ready,
    input  p_ctr, fetch_en, decode_en, exec_en, mem_en, wb_en, stat, busy
  );
`endif
endinterface

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle phase sequencer and PC owner for the SEQ Y86-64 core.
// Walks FETCH, DECODE, EXECUTE, MEMORY, WRBACK, PCUPD one phase per cycle
// (MEMORY may stretch while waiting for mem_ready), selects the next PC and
// turns fetch faults, halts and memory timeouts into the status code.
// Optional feature: define SEQ_CTRL_RETIRE_CNT_EN to add a saturating
// 32-bit retired-instruction counter on the interface.
module seq_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter logic [63:0] IMEM_LIMIT  = 64'd1023,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  seq_ctrl_if.master bus
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Last wait-count value at which a missing mem_ready becomes a timeout.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRBACK,
    S_PCUPD,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [63:0] val_m_q;
  logic [63:0] next_pc;

  // Next-PC selection from the instruction class; ret uses the value latched in MEMORY.
  always_comb begin
    next_pc = bus.val_p;
    case (bus.in_code)
      4'd8:    next_pc = bus.val_c;
      4'd7:    next_pc = bus.cnd ? bus.val_c : bus.val_p;
      4'd9:    next_pc = val_m_q;
      default: next_pc = bus.val_p;
    endcase
  end

  // Phase sequencer: each transition also sets the registered enables/busy for the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.p_ctr     <= RESET_PC;
      bus.stat      <= STAT_AOK;
      bus.fetch_en  <= 1'b0;
      bus.decode_en <= 1'b0;
      bus.exec_en   <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.wb_en     <= 1'b0;
      bus.busy      <= 1'b0;
      wait_cnt      <= 8'd0;
      val_m_q       <= 64'd0;
`ifdef SEQ_CTRL_RETIRE_CNT_EN
      bus.retired   <= 32'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.p_ctr > IMEM_LIMIT) begin
              state    <= S_FAULT;
              bus.stat <= STAT_ADR;
            end else begin
              state        <= S_FETCH;
              bus.fetch_en <= 1'b1;
              bus.busy     <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          state         <= S_DECODE;
          bus.fetch_en  <= 1'b0;
          bus.decode_en <= 1'b1;
        end
        S_DECODE: begin
          bus.decode_en <= 1'b0;
          if (bus.bad_mem) begin
            state    <= S_FAULT;
            bus.stat <= STAT_ADR;
            bus.busy <= 1'b0;
          end else if (bus.in_error) begin
            state    <= S_FAULT;
            bus.stat <= STAT_INS;
            bus.busy <= 1'b0;
          end else if (bus.flag_halt) begin
            state    <= S_HALTED;
            bus.stat <= STAT_HLT;
            bus.busy <= 1'b0;
          end else begin
            state       <= S_EXECUTE;
            bus.exec_en <= 1'b1;
          end
        end
        S_EXECUTE: begin
          state       <= S_MEMORY;
          bus.exec_en <= 1'b0;
          bus.mem_en  <= 1'b1;
          wait_cnt    <= 8'd0;
        end
        S_MEMORY: begin
          if (bus.mem_ready) begin
            val_m_q    <= bus.val_m;
            state      <= S_WRBACK;
            bus.mem_en <= 1'b0;
            bus.wb_en  <= 1'b1;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state      <= S_FAULT;
            bus.stat   <= STAT_ADR;
            bus.mem_en <= 1'b0;
            bus.busy   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WRBACK: begin
          state     <= S_PCUPD;
          bus.wb_en <= 1'b0;
        end
        S_PCUPD: begin
          bus.p_ctr <= next_pc;
          if (next_pc > IMEM_LIMIT) begin
            state    <= S_FAULT;
            bus.stat <= STAT_ADR;
            bus.busy <= 1'b0;
          end else begin
            state        <= S_FETCH;
            bus.fetch_en <= 1'b1;
`ifdef SEQ_CTRL_RETIRE_CNT_EN
            if (bus.retired != 32'hFFFF_FFFF) begin
              bus.retired <= bus.retired + 32'd1;
            end
`endif
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: scoreboard bench for seq_ctrl. The stimulus process plays
// directed and random instruction streams, predicts each next fetch PC or
// terminal status from the architectural next-PC rules, and queues the
// prediction; a monitor process pops and compares on every fetch and on
// every stop (status leaving AOK).
`timescale 1ns/1ps
module tb_seq_ctrl;

  localparam logic [63:0] RESET_PC    = 64'd0;
  localparam logic [63:0] IMEM_LIMIT  = 64'd1023;
  localparam int          MEM_TIMEOUT = 15;

  typedef struct {
    bit          stop;
    logic [63:0] pc;
    logic [2:0]  stat;
    int          lat;
    int          ret;
  } exp_t;

  typedef struct {
    logic [3:0]  code;
    logic [63:0] vp;
    logic [63:0] vc;
    logic [63:0] vm;
    bit          cnd;
    bit          halt;
    bit          badm;
    bit          ierr;
    int          wait_n;
  } instr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  seq_ctrl_if bus();

  seq_ctrl #(
    .RESET_PC   (RESET_PC),
    .IMEM_LIMIT (IMEM_LIMIT),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_evt = 0;
  logic [2:0]  prev_stat = 3'd1;
  logic [63:0] model_pc = 64'd0;
  int          model_ret = 0;
  bit          stopped = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare queued predictions on every fetch and every stop event.
  always @(negedge clock) begin : monitor
    exp_t e;
    cyc = cyc + 1;
    if (reset) begin
      prev_stat = bus.stat;
      last_evt  = cyc;
    end else begin
      if (bus.fetch_en === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_fetch: fetch at pc 0x%0h, required no fetch", bus.p_ctr);
        end else begin
          e = sb.pop_front();
          checkOutput("fetch_kind", 64'(e.stop), 64'd0);
          checkOutput("fetch_pc", bus.p_ctr, e.pc);
          checkOutput("fetch_stat", 64'(bus.stat), 64'd1);
          if (e.lat != 0) checkOutput("fetch_latency", 64'(cyc - last_evt), 64'(e.lat));
`ifdef SEQ_CTRL_RETIRE_CNT_EN
          checkOutput("fetch_retired", 64'(bus.retired), 64'(e.ret));
`endif
        end
        last_evt = cyc;
      end
      if (prev_stat == 3'd1 && bus.stat != 3'd1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_stop: stat 0x%0h, required no stop", bus.stat);
        end else begin
          e = sb.pop_front();
          checkOutput("stop_kind", 64'(e.stop), 64'd1);
          checkOutput("stop_pc", bus.p_ctr, e.pc);
          checkOutput("stop_stat", 64'(bus.stat), 64'(e.stat));
          checkOutput("stop_busy", 64'(bus.busy), 64'd0);
          checkOutput("stop_enables", 64'({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en}), 64'd0);
          checkOutput("stop_latency", 64'(cyc - last_evt), 64'(e.lat));
`ifdef SEQ_CTRL_RETIRE_CNT_EN
          checkOutput("stop_retired", 64'(bus.retired), 64'(e.ret));
`endif
        end
      end
      prev_stat = bus.stat;
    end
  end

  function automatic instr_t mk(input logic [3:0] code, input logic [63:0] vp, input logic [63:0] vc,
                                input logic [63:0] vm, input bit cnd, input int wait_n);
    instr_t i;
    i.code = code; i.vp = vp; i.vc = vc; i.vm = vm; i.cnd = cnd;
    i.halt = 1'b0; i.badm = 1'b0; i.ierr = 1'b0; i.wait_n = wait_n;
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    int r;
    i = mk(4'($urandom_range(0, 15)), model_pc + 64'($urandom_range(1, 10)),
           64'($urandom_range(0, 1023)), 64'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), $urandom_range(0, 4));
    r = $urandom_range(0, 99);
    if (r < 3) i.halt = 1'b1;
    else if (r < 5) i.badm = 1'b1;
    else if (r < 7) i.ierr = 1'b1;
    else if (r < 9) begin i.badm = 1'b1; i.ierr = 1'b1; i.halt = 1'b1; end
    else if (r < 11) i.wait_n = 1000;
    else if (r < 13) begin i.code = 4'd8; i.vc = 64'd1024 + 64'($urandom_range(0, 5000)); end
    return i;
  endfunction

  task automatic doReset();
    @(negedge clock); #2;
    reset = 1'b1;
    bus.start = 1'b0; bus.in_code = 4'd0; bus.val_p = 64'd0; bus.val_c = 64'd0;
    bus.flag_halt = 1'b0; bus.bad_mem = 1'b0; bus.in_error = 1'b0; bus.cnd = 1'b0;
    bus.val_m = 64'd0; bus.mem_ready = 1'b0;
    sb.delete();
    @(negedge clock); #2;
    reset = 1'b0;
    model_pc = RESET_PC;
    model_ret = 0;
    stopped = 1'b0;
  endtask

  task automatic startSession();
    exp_t e;
    e.stop = 1'b0; e.pc = model_pc; e.stat = 3'd1; e.lat = 0; e.ret = 0;
    sb.push_back(e);
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic finishSession();
    repeat (6) @(negedge clock);
    checkOutput("scoreboard_drain", 64'(sb.size()), 64'd0);
  endtask

  // Drive one instruction from its FETCH cycle through MEMORY and queue the predicted outcome.
  task automatic applyStimulus(input instr_t ins);
    exp_t        e;
    logic [63:0] npc;
    int          guard;
    int          k;
    guard = 0;
    while (bus.fetch_en !== 1'b1 && guard < 40) begin @(negedge clock); guard++; end
    if (bus.fetch_en !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL fetch_wait: no fetch_en in 40 cycles, required fetch at pc 0x%0h", model_pc);
      stopped = 1'b1;
      return;
    end
    bus.in_code = ins.code; bus.val_p = ins.vp; bus.val_c = ins.vc; bus.cnd = ins.cnd;
    bus.flag_halt = ins.halt; bus.bad_mem = ins.badm; bus.in_error = ins.ierr;
    bus.mem_ready = 1'b0;
    bus.start = 1'($urandom_range(0, 1));
    e.stop = 1'b0; e.pc = model_pc; e.stat = 3'd1; e.lat = 2; e.ret = model_ret;
    if (ins.badm) begin e.stop = 1'b1; e.stat = 3'd3; end
    else if (ins.ierr) begin e.stop = 1'b1; e.stat = 3'd4; end
    else if (ins.halt) begin e.stop = 1'b1; e.stat = 3'd2; end
    else begin
      if (ins.code == 4'd8) npc = ins.vc;
      else if (ins.code == 4'd7) npc = ins.cnd ? ins.vc : ins.vp;
      else if (ins.code == 4'd9) npc = ins.vm;
      else npc = ins.vp;
      if (ins.wait_n >= MEM_TIMEOUT) begin
        e.stop = 1'b1; e.stat = 3'd3; e.lat = 3 + MEM_TIMEOUT;
      end else begin
        e.pc = npc; e.lat = 6 + ins.wait_n; model_pc = npc;
        if (npc > IMEM_LIMIT) begin e.stop = 1'b1; e.stat = 3'd3; end
        else model_ret++;
        e.ret = model_ret;
      end
    end
    sb.push_back(e);
    if (e.stop && e.lat == 2) begin stopped = 1'b1; return; end
    guard = 0;
    while (bus.mem_en !== 1'b1 && guard < 10) begin @(negedge clock); guard++; end
    if (bus.mem_en !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL mem_wait: no mem_en in 10 cycles, required MEMORY phase");
      stopped = 1'b1;
      return;
    end
    k = 0;
    while (bus.mem_en === 1'b1 && k < 300) begin
      bus.val_m = ins.vm;
      bus.mem_ready = (k == ins.wait_n);
      @(negedge clock);
      k++;
    end
    bus.mem_ready = 1'b0;
    if (e.stop) stopped = 1'b1;
  endtask

  // Watchdog: never let the run hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin : stimulus
    instr_t hi;
    int     guard;
    doReset();
    #1;
    checkOutput("reset_pc", bus.p_ctr, RESET_PC);
    checkOutput("reset_stat", 64'(bus.stat), 64'd1);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_enables", 64'({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en}), 64'd0);

    $display("[TB] directed stream: nops, jXX both ways, ret with waits, boundary PCs");
    startSession();
    applyStimulus(mk(4'd1, 64'd1, 64'd0, 64'd0, 1'b0, 0));
    applyStimulus(mk(4'd1, 64'd2, 64'd0, 64'd0, 1'b0, 0));
    applyStimulus(mk(4'd1, 64'd3, 64'd0, 64'd0, 1'b0, 0));
    applyStimulus(mk(4'd7, 64'h09, 64'h40, 64'd0, 1'b1, 0));
    applyStimulus(mk(4'd7, 64'h09, 64'h40, 64'd0, 1'b0, 0));
    applyStimulus(mk(4'd9, 64'h0a, 64'h40, 64'h123, 1'b0, 3));
    applyStimulus(mk(4'd8, 64'h12c, 64'h200, 64'd0, 1'b0, MEM_TIMEOUT - 1));
    applyStimulus(mk(4'd1, 64'd1023, 64'd0, 64'd0, 1'b0, 1));
    applyStimulus(mk(4'd1, 64'd1024, 64'd0, 64'd0, 1'b0, 0));
    finishSession();

    $display("[TB] halt then ignored start");
    doReset();
    startSession();
    applyStimulus(mk(4'd1, 64'd1, 64'd0, 64'd0, 1'b0, 0));
    hi = mk(4'd0, 64'd2, 64'd0, 64'd0, 1'b0, 0);
    hi.halt = 1'b1;
    applyStimulus(hi);
    finishSession();
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("halted_pc", bus.p_ctr, 64'd1);
    checkOutput("halted_stat", 64'(bus.stat), 64'd2);
    checkOutput("halted_busy", 64'(bus.busy), 64'd0);

    $display("[TB] memory timeout");
    doReset();
    startSession();
    applyStimulus(mk(4'd1, 64'd1, 64'd0, 64'd0, 1'b0, 0));
    applyStimulus(mk(4'd5, 64'd2, 64'd0, 64'd0, 1'b0, 1000));
    finishSession();

    $display("[TB] fetch fault priority");
    doReset();
    startSession();
    hi = mk(4'd2, 64'd2, 64'd0, 64'd0, 1'b0, 0);
    hi.badm = 1'b1; hi.ierr = 1'b1;
    applyStimulus(hi);
    finishSession();
    doReset();
    startSession();
    hi = mk(4'd2, 64'd2, 64'd0, 64'd0, 1'b0, 0);
    hi.ierr = 1'b1; hi.halt = 1'b1;
    applyStimulus(hi);
    finishSession();

    $display("[TB] reset during MEMORY");
    doReset();
    startSession();
    applyStimulus(mk(4'd1, 64'd1, 64'd0, 64'd0, 1'b0, 0));
    guard = 0;
    while (bus.mem_en !== 1'b1 && guard < 20) begin @(negedge clock); guard++; end
    checkOutput("mid_mem_en", 64'(bus.mem_en), 64'd1);
    @(negedge clock);
`ifdef SEQ_CTRL_RETIRE_CNT_EN
    checkOutput("mid_retired", 64'(bus.retired), 64'd1);
`endif
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_pc", bus.p_ctr, RESET_PC);
    checkOutput("abort_stat", 64'(bus.stat), 64'd1);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_enables", 64'({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en}), 64'd0);
`ifdef SEQ_CTRL_RETIRE_CNT_EN
    checkOutput("abort_retired", 64'(bus.retired), 64'd0);
`endif

    $display("[TB] random streams");
    for (int s = 0; s < 5; s++) begin
      doReset();
      startSession();
      for (int n = 0; n < 25 && !stopped; n++) begin
        applyStimulus(randInstr());
      end
      if (stopped) finishSession();
    end

    doReset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle phase sequencer and PC owner for the SEQ Y86-64 core. Steps the fetch, decode, execute, memory and write-back units one phase at a time. Drives `p_ctr` into the fetch unit and selects the next PC from `val_p`, `val_c`, `val_m` and the condition flag. Converts fetch-side fault flags and memory timeouts into the architectural status code and stops the machine.

## Interface
Parameters:
- `RESET_PC`, 64'd0, PC value loaded on reset.
- `IMEM_LIMIT`, 64'd1023, highest legal instruction address; a PC above it faults before fetch.
- `MEM_TIMEOUT`, 15, maximum MEMORY-phase wait cycles for `mem_ready`; range 1..255.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin execution from current `p_ctr`; honoured only in IDLE.
- `in_code`  in  4  icode from fetch.
- `val_p`  in  64  fall-through PC from fetch.
- `val_c`  in  64  constant word from fetch.
- `flag_halt`  in  1  fetch decoded `halt`.
- `bad_mem`  in  1  fetch address error.
- `in_error`  in  1  fetch illegal-icode error.
- `cnd`  in  1  branch condition from execute; valid in PCUPD.
- `val_m`  in  64  value read by memory (return address); valid when `mem_ready`.
- `mem_ready`  in  1  memory phase complete.
- `p_ctr`  out  64  current PC to fetch.
- `fetch_en`, `decode_en`, `exec_en`, `mem_en`, `wb_en`  out  1 each  phase enables; one-hot or all zero.
- `stat`  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- `busy`  out  1  high in any state other than IDLE, HALTED or FAULT.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRBACK, PCUPD, HALTED, FAULT.
- **IDLE**
  - With `start`=1: if `p_ctr` > `IMEM_LIMIT`, `stat`=3 and go to FAULT.
  - Otherwise go to FETCH.
- **FETCH**: `fetch_en`=1; go to DECODE.
- **DECODE**: `decode_en`=1. Fetch outputs are sampled here with priority `bad_mem` (stat 3) > `in_error` (stat 4) > `flag_halt` (stat 2).
  - ADR or INS: go to FAULT.
  - HLT: go to HALTED.
  - Otherwise go to EXECUTE.
  - In every case `p_ctr` holds the faulting or halt address.
- **EXECUTE**: `exec_en`=1; go to MEMORY.
- **MEMORY**: `mem_en` held high. A wait counter starts at 0 on entry.
  - `mem_ready`=1: latch `val_m` and go to WRBACK.
  - Counter reaches `MEM_TIMEOUT` without `mem_ready`: `stat`=3 and go to FAULT.
- **WRBACK**: `wb_en`=1; go to PCUPD.
- **PCUPD**: load the next PC, then apply the same `IMEM_LIMIT` check.
  - Next PC selection:
    - `in_code`=8 (call): `val_c`.
    - `in_code`=7 (jXX): `cnd` ? `val_c` : `val_p`.
    - `in_code`=9 (ret): latched `val_m`.
    - All other codes: `val_p`.
  - New PC > `IMEM_LIMIT`: `stat`=3 and go to FAULT.
  - Otherwise go to FETCH.
- **HALTED and FAULT**: absorbing; only `reset` leaves them. `start` is ignored there and in all busy states.
- PC arithmetic is plain 64-bit. No wrap check beyond the `IMEM_LIMIT` compare.

## Timing
- Reset values: `p_ctr`=`RESET_PC`, all enables 0, `stat`=1, `busy`=0, state IDLE, wait counter 0.
- Reset mid-instruction aborts immediately; there is no partial PC update.
- All outputs are registered.
- Enables are asserted in the cycle the FSM occupies the matching state.
- Minimum instruction latency is 6 cycles (FETCH..PCUPD) with `mem_ready` asserted in the first MEMORY cycle.
- Each MEMORY wait cycle adds 1 to instruction latency.
- `mem_ready` asserted in the same cycle the timeout is reached counts as success; the ready wins.
- `p_ctr` changes only on the PCUPD edge.
- `stat` changes only on the edge entering HALTED or FAULT.

## Configuration
- `SEQ_CTRL_RETIRE_CNT_EN` defined:
  - Adds output `retired` (32 bits, reset 0).
  - Increments on every PCUPD exit to FETCH; saturates at 32'hFFFF_FFFF.
  - Does not increment for halt or faulting instructions.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- nop sequence (`in_code`=1, `val_p`=PC+1) from PC 0 with `mem_ready` tied high → `p_ctr` reads 0,1,2 at 6-cycle intervals; `stat`=1.
- jXX with `val_c`=0x40, `val_p`=0x09: `cnd`=1 → `p_ctr`=0x40; repeat with `cnd`=0 → `p_ctr`=0x09.
- ret with `val_m`=0x123 and `mem_ready` after 3 wait cycles → 9-cycle instruction; `p_ctr`=0x123.
- `flag_halt`=1 in DECODE → HALTED, `stat`=2, `busy`=0, `p_ctr` unchanged; a later `start` pulse has no effect.
- `mem_ready` never asserted with `MEM_TIMEOUT`=15 → FAULT, `stat`=3, after 15 MEMORY cycles; `bad_mem` and `in_error` both high → `stat`=3.
- `reset` asserted during MEMORY → same cycle: `p_ctr`=`RESET_PC`, enables 0, `stat`=1; with the macro defined, `retired` returns to 0.
